// File: rtl/sender_arbiter_if.sv
// Handshake bundle shared by the word requesters, the sender arbiter and the
// status sender's data_to_send/size_of_data/valid_data/busy port.
interface sender_arbiter_if #(
    parameter int REQUESTERS = 4,
    parameter int WORD_SIZE  = 32,
    parameter int SIZE_WORD  = 3
);
    localparam int GID_W = $clog2(REQUESTERS);

    logic [REQUESTERS-1:0]           req_valid;
    logic [REQUESTERS*WORD_SIZE-1:0] req_data;
    logic [REQUESTERS*SIZE_WORD-1:0] req_size;
    logic [REQUESTERS-1:0]           req_ack;
    logic                            busy;
    logic [WORD_SIZE-1:0]            data_to_send;
    logic [SIZE_WORD-1:0]            size_of_data;
    logic                            valid_data;
    logic [GID_W-1:0]                grant_id;
    logic                            active;
    logic                            timeout_err;

    // Arbiter side.
    modport master (
        input  req_valid, req_data, req_size, busy,
        output req_ack, data_to_send, size_of_data, valid_data, grant_id, active, timeout_err
    );

    // Requester / sender side.
    modport slave (
        output req_valid, req_data, req_size, busy,
        input  req_ack, data_to_send, size_of_data, valid_data, grant_id, active, timeout_err
    );
endinterface

// File: rtl/sender_arbiter.sv
// Round-robin arbiter and sequencer sharing one UART status sender among
// REQUESTERS word sources. One word is latched per grant, issued with a single
// valid_data strobe, and the sender's busy window is tracked until the word is
// out. A sender that never raises busy is abandoned after BUSY_TIMEOUT cycles.
module sender_arbiter #(
    parameter int REQUESTERS   = 4,
    parameter int WORD_SIZE    = 32,
    parameter int SIZE_WORD    = 3,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    sender_arbiter_if.master bus
);
    localparam int GID_W = $clog2(REQUESTERS);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                  state_q;
    logic [GID_W-1:0]        ptr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [REQUESTERS-1:0]   req_ack_q;
    logic [WORD_SIZE-1:0]    data_q;
    logic [SIZE_WORD-1:0]    size_q;
    logic                    valid_q;
    logic [GID_W-1:0]        grant_id_q;
    logic                    active_q;
    logic                    timeout_q;

    logic [REQUESTERS-1:0]   elig_d;
    logic                    grant_found_d;
    logic [GID_W-1:0]        grant_idx_d;
    logic [REQUESTERS-1:0]   grant_onehot_d;
    logic [WORD_SIZE-1:0]    grant_data_d;
    logic [SIZE_WORD-1:0]    grant_size_d;

    // Index arithmetic modulo REQUESTERS (works for non-power-of-two counts).
    function automatic logic [GID_W-1:0] wrap_add(input logic [GID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        sum = (sum >= REQUESTERS) ? (sum - REQUESTERS) : sum;
        return GID_W'(sum);
    endfunction

    // Pick the first eligible requester at or after the round-robin pointer.
    // The requester acked last cycle is masked: its req_valid still shows the
    // word just consumed, since it only updates in the cycle after the ack.
    always_comb begin
        elig_d        = bus.req_valid & ~req_ack_q;
        grant_found_d = 1'b0;
        grant_idx_d   = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (!grant_found_d && elig_d[wrap_add(ptr_q, i)]) begin
                grant_found_d = 1'b1;
                grant_idx_d   = wrap_add(ptr_q, i);
            end else begin
                grant_found_d = grant_found_d;
            end
        end
        grant_onehot_d              = '0;
        grant_onehot_d[grant_idx_d] = 1'b1;
        grant_data_d = bus.req_data[int'(grant_idx_d)*WORD_SIZE +: WORD_SIZE];
        grant_size_d = bus.req_size[int'(grant_idx_d)*SIZE_WORD +: SIZE_WORD];
    end

    // Grant/issue/busy-tracking state machine; every output comes from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            req_ack_q  <= '0;
            data_q     <= '0;
            size_q     <= '0;
            valid_q    <= 1'b0;
            grant_id_q <= '0;
            active_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            req_ack_q <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!bus.busy && grant_found_d) begin
                        req_ack_q  <= grant_onehot_d;
                        grant_id_q <= grant_idx_d;
                        ptr_q      <= wrap_add(grant_idx_d, 1);
                        data_q     <= grant_data_d;
                        size_q     <= grant_size_d;
                        if (grant_size_d != {SIZE_WORD{1'b0}}) begin
                            state_q  <= ISSUE;
                            active_q <= 1'b1;
                        end else begin
                            // Empty word: consumed without bothering the sender.
                            state_q  <= IDLE;
                            active_q <= 1'b0;
                        end
                    end else begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    valid_q  <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= WAIT_BUSY;
                    active_q <= 1'b1;
                end
                WAIT_BUSY: begin
                    if (bus.busy) begin
                        state_q  <= WAIT_DONE;
                        active_q <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        // Sender never took the word; drop it and free the path.
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                        active_q  <= 1'b0;
                    end else begin
                        cnt_q    <= cnt_q + CNT_W'(1);
                        state_q  <= WAIT_BUSY;
                        active_q <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    // No timeout here: frame length depends on the UART prescaler.
                    if (!bus.busy) begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                    end else begin
                        state_q  <= WAIT_DONE;
                        active_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ack      = req_ack_q;
    assign bus.data_to_send = data_q;
    assign bus.size_of_data = size_q;
    assign bus.valid_data   = valid_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.active       = active_q;
    assign bus.timeout_err  = timeout_q;
endmodule

// File: tb/tb_sender_arbiter.sv
// Scoreboard bench for sender_arbiter: each round queues words per requester,
// a transaction-level round-robin model predicts the grant order, and a monitor
// checks acks, issues and timeouts as the DUT produces them.
module tb_sender_arbiter;
    localparam int R  = 4;
    localparam int W  = 32;
    localparam int S  = 3;
    localparam int TO = 15;

    typedef struct { logic [W-1:0] data; logic [S-1:0] size; } word_t;
    typedef struct { int gid; logic [W-1:0] data; logic [S-1:0] size; int cyc; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [R-1:0]   req_valid_r = '0;
    logic [R*W-1:0] req_data_r  = '0;
    logic [R*S-1:0] req_size_r  = '0;
    logic sender_busy = 1'b0;
    logic hold_busy   = 1'b0;

    sender_arbiter_if #(.REQUESTERS(R), .WORD_SIZE(W), .SIZE_WORD(S)) bus ();

    sender_arbiter #(.REQUESTERS(R), .WORD_SIZE(W), .SIZE_WORD(S), .BUSY_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign bus.req_valid = req_valid_r;
    assign bus.req_data  = req_data_r;
    assign bus.req_size  = req_size_r;
    assign bus.busy      = sender_busy | hold_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int model_ptr = 0;
    int rst_epoch = 0;
    int force_mode = 0;   // 0 random sender, 1 fixed delay/length, 2 never busy
    int force_d = 1;
    int force_len = 1;
    bit sender_idle = 1'b1;
    bit prev_busy = 1'b0;

    word_t wq[R][$];
    exp_t  exp_grant[$];
    exp_t  exp_issue[$];
    int    exp_to[$];

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_word(input int i, input logic [W-1:0] d, input logic [S-1:0] s);
        word_t w;
        w.data = d;
        w.size = s;
        wq[i].push_back(w);
    endtask

    task automatic present(input int i);
        req_valid_r[i]         = 1'b1;
        req_data_r[i*W +: W]   = wq[i][0].data;
        req_size_r[i*S +: S]   = wq[i][0].size;
    endtask

    // Reference: every queued word is eventually granted; the winner is always
    // the first requester with words left at or after the pointer.
    task automatic build_expected();
        int left[R];
        int pos[R];
        int total;
        exp_t e;
        total = 0;
        for (int i = 0; i < R; i++) begin left[i] = wq[i].size(); pos[i] = 0; total += left[i]; end
        while (total > 0) begin
            for (int k = 0; k < R; k++) begin
                int g;
                g = (model_ptr + k) % R;
                if (left[g] > 0) begin
                    e.gid = g; e.data = wq[g][pos[g]].data; e.size = wq[g][pos[g]].size; e.cyc = 0;
                    exp_grant.push_back(e);
                    pos[g]++; left[g]--; total--;
                    model_ptr = (g + 1) % R;
                    break;
                end
            end
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            done = (exp_grant.size() == 0) && (exp_issue.size() == 0) && (exp_to.size() == 0) &&
                   !bus.active && sender_idle && (req_valid_r == '0);
        end
        chk("round_drain", done, 1);
    endtask

    task automatic run_round(input int hold);
        int first_gid;
        logic [R-1:0] onehot;
        build_expected();
        first_gid = exp_grant[0].gid;
        @(posedge clk); #1;
        if (hold > 0) hold_busy = 1'b1;
        for (int i = 0; i < R; i++) if (wq[i].size() > 0) present(i);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 hold_busy = 1'b0;
            @(posedge clk);
            @(negedge clk);
            onehot = '0;
            onehot[first_gid] = 1'b1;
            chk("ack_after_busy_release", bus.req_ack, onehot);
        end
        drain();
    endtask

    // Requesters: after an ack, present the next queued word or withdraw.
    initial begin
        logic [R-1:0] acked;
        forever begin
            @(negedge clk);
            acked = bus.req_ack;
            if (acked != '0 && !rst) begin
                @(posedge clk); #1;
                for (int i = 0; i < R; i++) begin
                    if (acked[i]) begin
                        void'(wq[i].pop_front());
                        if (wq[i].size() > 0) present(i); else req_valid_r[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Sender model: reacts to valid_data with a busy window or by ignoring it.
    initial begin
        int v, d, len, ep;
        forever begin
            @(negedge clk);
            if (bus.valid_data && !rst) begin
                sender_idle = 1'b0;
                v = cyc;
                ep = rst_epoch;
                if (force_mode == 2 || (force_mode == 0 && $urandom_range(0, 5) == 0)) begin
                    exp_to.push_back(v + TO);
                end else begin
                    d   = (force_mode == 1) ? force_d   : $urandom_range(1, 3);
                    len = (force_mode == 1) ? force_len : $urandom_range(1, 8);
                    repeat (d) @(posedge clk);
                    #1 sender_busy = 1'b1;
                    repeat (len) @(posedge clk);
                    #1 sender_busy = 1'b0;
                    @(negedge clk);
                    if (ep == rst_epoch) chk("active_while_busy_falls", bus.active, 1);
                    @(negedge clk);
                    if (ep == rst_epoch) chk("active_after_busy_fell", bus.active, 0);
                end
                sender_idle = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an ack, issue or timeout.
    initial begin
        exp_t e;
        logic [R-1:0] onehot;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.req_ack != '0) begin
                    chk("ack_while_busy", prev_busy, 0);
                    if (exp_grant.size() == 0) begin
                        chk("unexpected_ack", bus.req_ack, 0);
                    end else begin
                        e = exp_grant.pop_front();
                        onehot = '0;
                        onehot[e.gid] = 1'b1;
                        chk("ack_onehot", bus.req_ack, onehot);
                        if (e.size != '0) begin e.cyc = cyc; exp_issue.push_back(e); end
                    end
                end
                if (bus.valid_data) begin
                    chk("valid_with_timeout", bus.timeout_err, 0);
                    if (exp_issue.size() == 0) begin
                        chk("unexpected_issue", bus.valid_data, 0);
                    end else begin
                        e = exp_issue.pop_front();
                        chk("issue_latency", cyc, e.cyc + 1);
                        chk("issue_data", bus.data_to_send, e.data);
                        chk("issue_size", bus.size_of_data, e.size);
                        chk("issue_grant_id", bus.grant_id, e.gid);
                    end
                end
                if (bus.timeout_err) begin
                    if (exp_to.size() == 0) chk("unexpected_timeout", bus.timeout_err, 0);
                    else chk("timeout_cycle", cyc, exp_to.pop_front());
                end
            end
            prev_busy = bus.busy;
        end
    end

    initial begin
        bit ok;
        int hold;
        logic [3:0] mask;
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ack", bus.req_ack, 0);
        chk("rst_valid_data", bus.valid_data, 0);
        chk("rst_active", bus.active, 0);
        chk("rst_grant_id", bus.grant_id, 0);
        chk("rst_timeout", bus.timeout_err, 0);
        chk("rst_data", bus.data_to_send, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Zero-size word from req 1 with req 3 pending.
        add_word(1, 32'h1111_2222, 3'd0);
        add_word(3, 32'hCAFE_0003, 3'd5);
        run_round(0);

        // Single request, sender busy 2 cycles after issue for 40 cycles.
        force_mode = 1; force_d = 2; force_len = 40;
        add_word(2, 32'hDEAD_BEEF, 3'd4);
        run_round(0);

        // All four requesters with 10-cycle busy windows, two words each.
        force_d = 1; force_len = 10;
        for (int i = 0; i < R; i++) begin
            add_word(i, $urandom(), 3'($urandom_range(1, 7)));
            add_word(i, $urandom(), 3'($urandom_range(1, 7)));
        end
        run_round(0);

        // Sender never goes busy: timeout, then a normal grant afterwards.
        force_mode = 2;
        add_word(0, 32'h0000_7070, 3'd3);
        run_round(0);
        force_mode = 0;
        add_word(1, 32'h0000_8181, 3'd2);
        run_round(0);

        // Busy already high in IDLE with req 0 pending.
        add_word(0, 32'h5555_AAAA, 3'd6);
        run_round(5);

        // Randomised rounds.
        for (int r = 0; r < 40; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < R; i++) begin
                if (mask[i]) begin
                    for (int k = 0, n = $urandom_range(1, 3); k < n; k++)
                        add_word(i, $urandom(), ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7)));
                end
            end
            hold = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
            run_round(hold);
        end

        // Reset in WAIT_DONE with more requests pending.
        force_mode = 1; force_d = 1; force_len = 30;
        add_word(1, 32'hAAAA_0001, 3'd1);
        add_word(2, 32'hAAAA_0002, 3'd2);
        add_word(3, 32'hAAAA_0003, 3'd3);
        build_expected();
        @(posedge clk); #1;
        for (int i = 0; i < R; i++) if (wq[i].size() > 0) present(i);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin @(negedge clk); ok = bus.valid_data; end
        chk("reset_phase_issue", ok, 1);
        repeat (3) @(negedge clk);
        chk("active_in_wait_done", bus.active, 1);
        @(posedge clk); #1 rst = 1'b1; rst_epoch++;
        @(posedge clk); #1 rst = 1'b0;
        exp_grant.delete(); exp_issue.delete(); exp_to.delete();
        model_ptr = 0;
        build_expected();
        force_mode = 0;
        @(negedge clk);
        chk("midrst_active", bus.active, 0);
        chk("midrst_valid_data", bus.valid_data, 0);
        chk("midrst_grant_id", bus.grant_id, 0);
        chk("midrst_req_ack", bus.req_ack, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
